// File: rtl/ddr5_phy_read_gate_ctrl_if.sv
// Command-side inputs and gate/window outputs of the DDR5 PHY read gate controller.
// The master drives the CA/mode inputs; the slave returns the gate and window outputs.
interface ddr5_phy_read_gate_ctrl_if #(
    parameter int pNUM_RANK = 1
);
    logic                 enable_i;
    logic [13:0]          command_address_i;
    logic [pNUM_RANK-1:0] chip_select_i;
    logic [1:0]           burst_length_i;
    logic [2:0]           num_pre_cycle_i;
    logic                 num_post_cycle_i;
    logic                 dram_crc_en_i;
    logic [6:0]           read_latency_i;

    logic                 dqs_gate_o;
    logic                 rd_window_o;
    logic                 rd_burst_start_o;
    logic [pNUM_RANK-1:0] rd_rank_o;
    logic [2:0]           outstanding_o;
    logic                 overflow_o;

    modport master (
        output enable_i, command_address_i, chip_select_i, burst_length_i,
               num_pre_cycle_i, num_post_cycle_i, dram_crc_en_i, read_latency_i,
        input  dqs_gate_o, rd_window_o, rd_burst_start_o, rd_rank_o,
               outstanding_o, overflow_o
    );

    modport slave (
        input  enable_i, command_address_i, chip_select_i, burst_length_i,
               num_pre_cycle_i, num_post_cycle_i, dram_crc_en_i, read_latency_i,
        output dqs_gate_o, rd_window_o, rd_burst_start_o, rd_rank_o,
               outstanding_o, overflow_o
    );
endinterface

// File: rtl/ddr5_phy_read_gate_ctrl.sv
// Tracks outstanding DDR5 reads in a small slot pool and generates the merged DQS
// receive gate, read data window and burst-start pulse from per-slot down-counters.
module ddr5_phy_read_gate_ctrl #(
    parameter int pNUM_RANK = 1,
    parameter int pNUM_SLOT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ddr5_phy_read_gate_ctrl_if.slave    bus
);
    localparam int SW = (pNUM_SLOT > 1) ? $clog2(pNUM_SLOT) : 1;

    // dist_q counts down to the first data clock: 0 at T+RL, negative through the burst.
    logic [pNUM_SLOT-1:0]  busy_q;
    logic [pNUM_SLOT-1:0]  par_pend_q;
    logic signed [8:0]     dist_q   [pNUM_SLOT];
    logic [pNUM_RANK-1:0]  cs_q     [pNUM_SLOT];
    logic [4:0]            burst_q  [pNUM_SLOT];
    logic [4:0]            tail_q   [pNUM_SLOT];
    logic [2:0]            pre_q    [pNUM_SLOT];

    logic                  second_q;
    logic                  overflow_q;
    logic                  gate_q;
    logic                  win_q;
    logic                  start_q;
    logic [pNUM_RANK-1:0]  rank_q;
    logic [2:0]            outstanding_q;

    logic [4:0]            burst_clk;
    logic [2:0]            pre_clk;
    logic [1:0]            post_clk;
    logic                  detect;

    logic signed [8:0]     dist_nxt [pNUM_SLOT];
    logic [pNUM_SLOT-1:0]  slot_gate;
    logic [pNUM_SLOT-1:0]  slot_win;
    logic [pNUM_SLOT-1:0]  slot_start;
    logic [pNUM_SLOT-1:0]  slot_end;
    logic [pNUM_SLOT-1:0]  busy_nxt;
    logic                  have_free;
    logic [SW-1:0]         free_idx;
    logic                  accept;
    logic [2:0]            cnt_nxt;
    logic [pNUM_RANK-1:0]  rank_nxt;
    logic                  unused_ca;

    assign unused_ca = ^bus.command_address_i[13:5];

    always_comb begin
        case (bus.burst_length_i)
            2'b01:   burst_clk = 5'd4;
            2'b10:   burst_clk = 5'd16;
            default: burst_clk = 5'd8;
        endcase
        if (bus.dram_crc_en_i) burst_clk = burst_clk + 5'd1;

        case (bus.num_pre_cycle_i)
            3'b000:  pre_clk = 3'd1;
            3'b011:  pre_clk = 3'd3;
            3'b100:  pre_clk = 3'd4;
            default: pre_clk = 3'd2;
        endcase

        post_clk = bus.num_post_cycle_i ? 2'd2 : 2'd1;
    end

    // The cycle after an accepted read is its second CA cycle and never a new command.
    assign detect = bus.enable_i && !second_q && !(&bus.chip_select_i) &&
                    (bus.command_address_i[4:0] == 5'b01111);

    always_comb begin
        slot_gate  = '0;
        slot_win   = '0;
        slot_start = '0;
        slot_end   = '0;
        have_free  = 1'b0;
        free_idx   = '0;
        cnt_nxt    = '0;
        rank_nxt   = rank_q;
        for (int s = 0; s < pNUM_SLOT; s++) begin
            dist_nxt[s] = dist_q[s] - 9'sd1;
            if (busy_q[s]) begin
                slot_gate[s]  = (dist_nxt[s] <= $signed({6'd0, pre_q[s]})) &&
                                (dist_nxt[s] > -$signed({4'd0, tail_q[s]}));
                slot_win[s]   = (dist_nxt[s] <= 9'sd0) &&
                                (dist_nxt[s] > -$signed({4'd0, burst_q[s]}));
                slot_start[s] = (dist_nxt[s] == 9'sd0);
                slot_end[s]   = (dist_nxt[s] == -$signed({4'd0, tail_q[s]}));
            end
        end
        busy_nxt = busy_q & ~slot_end;
        for (int s = pNUM_SLOT - 1; s >= 0; s--) begin
            if (!busy_nxt[s]) begin
                have_free = 1'b1;
                free_idx  = SW'(s);
            end
            if (slot_start[s]) rank_nxt = cs_q[s];
        end
        accept = detect && have_free;
        if (accept) busy_nxt[free_idx] = 1'b1;
        for (int s = 0; s < pNUM_SLOT; s++) begin
            cnt_nxt = cnt_nxt + {2'b00, busy_nxt[s]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q        <= '0;
            par_pend_q    <= '0;
            second_q      <= 1'b0;
            overflow_q    <= 1'b0;
            gate_q        <= 1'b0;
            win_q         <= 1'b0;
            start_q       <= 1'b0;
            rank_q        <= '0;
            outstanding_q <= '0;
            for (int s = 0; s < pNUM_SLOT; s++) begin
                dist_q[s]  <= '0;
                cs_q[s]    <= '0;
                burst_q[s] <= '0;
                tail_q[s]  <= '0;
                pre_q[s]   <= '0;
            end
        end else begin
            busy_q     <= busy_nxt;
            par_pend_q <= '0;
            for (int s = 0; s < pNUM_SLOT; s++) begin
                if (busy_q[s]) dist_q[s] <= dist_nxt[s];
                // Window shape comes from the second CA cycle, once BL is resolved.
                if (par_pend_q[s]) begin
                    burst_q[s] <= burst_clk;
                    tail_q[s]  <= burst_clk + {3'b000, post_clk};
                    pre_q[s]   <= pre_clk;
                end
            end
            if (accept) begin
                dist_q[free_idx]     <= $signed({2'b00, bus.read_latency_i});
                cs_q[free_idx]       <= bus.chip_select_i;
                par_pend_q[free_idx] <= 1'b1;
            end
            if (detect && !have_free) overflow_q <= 1'b1;
            second_q      <= accept;
            gate_q        <= |slot_gate;
            win_q         <= |slot_win;
            start_q       <= |slot_start;
            rank_q        <= rank_nxt;
            outstanding_q <= cnt_nxt;
        end
    end

    assign bus.dqs_gate_o       = gate_q;
    assign bus.rd_window_o      = win_q;
    assign bus.rd_burst_start_o = start_q;
    assign bus.rd_rank_o        = rank_q;
    assign bus.outstanding_o    = outstanding_q;
    assign bus.overflow_o       = overflow_q;
endmodule

// File: tb/tb_ddr5_phy_read_gate_ctrl.sv
// Directed bench for the read gate controller: single-read timing table plus
// hand-written sequences for overlap, overflow, mid-window reset and enable gating.
module tb_ddr5_phy_read_gate_ctrl;
    localparam int NR = 2;
    localparam int NS = 4;
    localparam int NE = 160;

    logic clk = 1'b0;
    logic rst;
    ddr5_phy_read_gate_ctrl_if #(.pNUM_RANK(NR)) bus ();

    ddr5_phy_read_gate_ctrl #(.pNUM_RANK(NR), .pNUM_SLOT(NS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         rl;
        logic [1:0] bl;
        logic [2:0] pre;
        logic       post;
        logic       crc;
        logic [1:0] cs;
        int         g0, g1, w0, w1;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    bit         rd_at     [NE];
    bit         en_off_at [NE];
    bit         rst_at    [NE];
    logic [1:0] cs_at     [NE];
    int         rl_v;
    logic [1:0] bl_v;
    logic [2:0] pre_v;
    logic       post_v, crc_v;

    bit         gate_tr [NE];
    bit         win_tr  [NE];
    bit         st_tr   [NE];
    bit         ovf_tr  [NE];
    logic [1:0] rank_tr [NE];
    int         out_tr  [NE];

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int e = 0; e < NE; e++) begin
            rd_at[e] = 1'b0; en_off_at[e] = 1'b0; rst_at[e] = 1'b0; cs_at[e] = 2'b11;
        end
    endtask

    task automatic drive(input int e, input bit skew);
        rst          = !rst_at[e];
        bus.enable_i = !en_off_at[e];
        if (rd_at[e] || (skew && e == 1)) begin
            bus.command_address_i = {9'h15A, 5'b01111};
            bus.chip_select_i     = cs_at[e];
        end else begin
            bus.command_address_i = {9'h0F3, 5'b00111};
            bus.chip_select_i     = 2'b11;
        end
        // Away from the second CA cycle the window parameters are deliberately wrong.
        if (skew && e != 1) begin
            bus.burst_length_i   = bl_v ^ 2'b01;
            bus.num_pre_cycle_i  = (pre_v == 3'b100) ? 3'b000 : 3'b100;
            bus.num_post_cycle_i = ~post_v;
            bus.dram_crc_en_i    = ~crc_v;
        end else begin
            bus.burst_length_i   = bl_v;
            bus.num_pre_cycle_i  = pre_v;
            bus.num_post_cycle_i = post_v;
            bus.dram_crc_en_i    = crc_v;
        end
        bus.read_latency_i = (skew && e != 0) ? 7'(rl_v ^ 64) : 7'(rl_v);
    endtask

    task automatic run(input int n, input bit skew);
        for (int e = 0; e < n; e++) begin
            drive(e, skew);
            @(posedge clk);
            #1;
            gate_tr[e] = bus.dqs_gate_o;
            win_tr[e]  = bus.rd_window_o;
            st_tr[e]   = bus.rd_burst_start_o;
            ovf_tr[e]  = bus.overflow_o;
            rank_tr[e] = bus.rd_rank_o;
            out_tr[e]  = int'(bus.outstanding_o);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.enable_i = 1'b0;
        bus.command_address_i = '0;
        bus.chip_select_i = 2'b11;
        bus.burst_length_i = '0;
        bus.num_pre_cycle_i = '0;
        bus.num_post_cycle_i = 1'b0;
        bus.dram_crc_en_i = 1'b0;
        bus.read_latency_i = 7'd20;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic bit tr_bit(input int sel, input int e);
        case (sel)
            0:       return gate_tr[e];
            1:       return win_tr[e];
            2:       return st_tr[e];
            default: return ovf_tr[e];
        endcase
    endfunction

    function automatic int first_hi(input int sel, input int lo, input int hi);
        for (int e = lo; e <= hi; e++) if (tr_bit(sel, e)) return e;
        return -1;
    endfunction

    function automatic int last_hi(input int sel, input int lo, input int hi);
        for (int e = hi; e >= lo; e--) if (tr_bit(sel, e)) return e;
        return -1;
    endfunction

    function automatic int cnt_hi(input int sel, input int lo, input int hi);
        int c = 0;
        for (int e = lo; e <= hi; e++) if (tr_bit(sel, e)) c++;
        return c;
    endfunction

    function automatic int max_out(input int lo, input int hi);
        int m = 0;
        for (int e = lo; e <= hi; e++) if (out_tr[e] > m) m = out_tr[e];
        return m;
    endfunction

    initial begin
        tbl[0] = '{20,  2'b00, 3'b010, 1'b0, 1'b0, 2'b10, 18,  28,  20,  27};
        tbl[1] = '{12,  2'b01, 3'b100, 1'b1, 1'b1, 2'b01, 8,   18,  12,  16};
        tbl[2] = '{8,   2'b10, 3'b000, 1'b1, 1'b0, 2'b00, 7,   25,  8,   23};
        tbl[3] = '{127, 2'b11, 3'b011, 1'b0, 1'b1, 2'b10, 124, 136, 127, 135};
        tbl[4] = '{30,  2'b00, 3'b111, 1'b1, 1'b0, 2'b01, 28,  39,  30,  37};
        tbl[5] = '{9,   2'b01, 3'b001, 1'b0, 1'b0, 2'b10, 7,   13,  9,   12};

        rl_v = 20; bl_v = 2'b00; pre_v = 3'b010; post_v = 1'b0; crc_v = 1'b0;
        do_reset();
        check("rst gate",  bus.dqs_gate_o, 0);
        check("rst win",   bus.rd_window_o, 0);
        check("rst start", bus.rd_burst_start_o, 0);
        check("rst rank",  bus.rd_rank_o, 0);
        check("rst outst", bus.outstanding_o, 0);
        check("rst ovf",   bus.overflow_o, 0);

        // Single reads; CA repeats the read pattern on the second cycle.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            clear_stim();
            rl_v = tbl[i].rl; bl_v = tbl[i].bl; pre_v = tbl[i].pre;
            post_v = tbl[i].post; crc_v = tbl[i].crc;
            rd_at[0] = 1'b1; cs_at[0] = tbl[i].cs; cs_at[1] = tbl[i].cs;
            run(145, 1'b1);
            check($sformatf("v%0d gate_first", i), first_hi(0, 0, 144), tbl[i].g0);
            check($sformatf("v%0d gate_last", i),  last_hi(0, 0, 144), tbl[i].g1);
            check($sformatf("v%0d gate_len", i),   cnt_hi(0, 0, 144), tbl[i].g1 - tbl[i].g0 + 1);
            check($sformatf("v%0d win_first", i),  first_hi(1, 0, 144), tbl[i].w0);
            check($sformatf("v%0d win_last", i),   last_hi(1, 0, 144), tbl[i].w1);
            check($sformatf("v%0d win_len", i),    cnt_hi(1, 0, 144), tbl[i].w1 - tbl[i].w0 + 1);
            check($sformatf("v%0d start_cnt", i),  cnt_hi(2, 0, 144), 1);
            check($sformatf("v%0d start_at", i),   first_hi(2, 0, 144), tbl[i].w0);
            check($sformatf("v%0d rank", i),       rank_tr[tbl[i].w0], int'(tbl[i].cs));
            check($sformatf("v%0d busy_at_end", i), out_tr[tbl[i].g1], 1);
            check($sformatf("v%0d freed", i),      out_tr[tbl[i].g1 + 1], 0);
            check($sformatf("v%0d max_outst", i),  max_out(0, 144), 1);
            check($sformatf("v%0d no_ovf", i),     cnt_hi(3, 0, 144), 0);
        end

        // Two overlapping reads 8 clocks apart: abutting windows must merge.
        do_reset();
        clear_stim();
        rl_v = 20; bl_v = 2'b00; pre_v = 3'b010; post_v = 1'b0; crc_v = 1'b0;
        rd_at[0] = 1'b1; cs_at[0] = 2'b10;
        rd_at[8] = 1'b1; cs_at[8] = 2'b01;
        run(60, 1'b0);
        check("ovl gate_first", first_hi(0, 0, 59), 18);
        check("ovl gate_last",  last_hi(0, 0, 59), 36);
        check("ovl gate_len",   cnt_hi(0, 0, 59), 19);
        check("ovl win_first",  first_hi(1, 0, 59), 20);
        check("ovl win_last",   last_hi(1, 0, 59), 35);
        check("ovl win_len",    cnt_hi(1, 0, 59), 16);
        check("ovl start_cnt",  cnt_hi(2, 0, 59), 2);
        check("ovl start1",     first_hi(2, 0, 59), 20);
        check("ovl start2",     last_hi(2, 0, 59), 28);
        check("ovl max_outst",  max_out(0, 59), 2);
        check("ovl outst_29",   out_tr[29], 1);
        check("ovl rank_27",    rank_tr[27], 2'b10);
        check("ovl rank_28",    rank_tr[28], 2'b01);

        // Five reads two clocks apart with four slots: the fifth is dropped.
        do_reset();
        clear_stim();
        rl_v = 40;
        for (int k = 0; k < 5; k++) begin
            rd_at[2 * k] = 1'b1; cs_at[2 * k] = 2'b10;
        end
        run(70, 1'b0);
        check("ovf start_cnt",  cnt_hi(2, 0, 69), 4);
        check("ovf start_last", last_hi(2, 0, 69), 46);
        check("ovf flag_7",     ovf_tr[7], 0);
        check("ovf flag_8",     ovf_tr[8], 1);
        check("ovf flag_69",    ovf_tr[69], 1);
        check("ovf max_outst",  max_out(0, 69), 4);
        check("ovf gate_first", first_hi(0, 0, 69), 38);
        check("ovf gate_last",  last_hi(0, 0, 69), 54);
        check("ovf gate_len",   cnt_hi(0, 0, 69), 17);
        check("ovf win_len",    cnt_hi(1, 0, 69), 14);

        // Reset in the middle of a window, then a fresh read.
        do_reset();
        clear_stim();
        rl_v = 20;
        rd_at[0] = 1'b1; cs_at[0] = 2'b10;
        rst_at[22] = 1'b1;
        rd_at[25] = 1'b1; cs_at[25] = 2'b01;
        run(70, 1'b0);
        check("mrst win_21",     win_tr[21], 1);
        check("mrst gate_22",    gate_tr[22], 0);
        check("mrst win_22",     win_tr[22], 0);
        check("mrst outst_22",   out_tr[22], 0);
        check("mrst rank_22",    rank_tr[22], 0);
        check("mrst gate_first", first_hi(0, 22, 69), 43);
        check("mrst gate_last",  last_hi(0, 22, 69), 53);
        check("mrst gate_len",   cnt_hi(0, 22, 69), 11);
        check("mrst win_first",  first_hi(1, 22, 69), 45);
        check("mrst win_last",   last_hi(1, 22, 69), 52);
        check("mrst start_at",   first_hi(2, 22, 69), 45);
        check("mrst rank_45",    rank_tr[45], 2'b01);

        // enable low blocks new captures but the pending window completes.
        do_reset();
        clear_stim();
        rl_v = 20;
        rd_at[0] = 1'b1; cs_at[0] = 2'b01;
        for (int e = 5; e <= 40; e++) en_off_at[e] = 1'b1;
        rd_at[5] = 1'b1;  cs_at[5] = 2'b10;
        rd_at[10] = 1'b1; cs_at[10] = 2'b10;
        rd_at[30] = 1'b1; cs_at[30] = 2'b10;
        run(60, 1'b0);
        check("en gate_first", first_hi(0, 0, 59), 18);
        check("en gate_last",  last_hi(0, 0, 59), 28);
        check("en gate_len",   cnt_hi(0, 0, 59), 11);
        check("en start_cnt",  cnt_hi(2, 0, 59), 1);
        check("en max_outst",  max_out(0, 59), 1);
        check("en rank_20",    rank_tr[20], 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ddr5_phy_read_gate_ctrl.md
DDR5_PHY_READ_GATE_CTRL -- requirements
Module: ddr5_phy_read_gate_ctrl

Interface
REQ-001 pNUM_RANK, default 1, number of chip-select ranks.
REQ-002 pNUM_SLOT, default 4, number of outstanding read tracking slots.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-low reset.
REQ-005 enable_i  input  1  permits capture of new read commands.
REQ-006 command_address_i  input  14  CA bus as driven by the CA manager.
REQ-007 chip_select_i  input  pNUM_RANK  active-low chip selects from the CA manager.
REQ-008 burst_length_i  input  2  resolved burst length: 00 BL16, 01 BC8, 10 BL32, 11 BL16.
REQ-009 num_pre_cycle_i  input  3  MR8 read preamble code.
REQ-010 num_post_cycle_i  input  1  MR8 read postamble code.
REQ-011 dram_crc_en_i  input  1  read CRC enabled.
REQ-012 read_latency_i  input  7  RL in clocks; legal range 8..127.
REQ-013 dqs_gate_o  output  1  DQS receive gate.
REQ-014 rd_window_o  output  1  read data valid window.
REQ-015 rd_burst_start_o  output  1  one-cycle pulse at first data clock.
REQ-016 rd_rank_o  output  pNUM_RANK  active-low CS of the most recently started burst.
REQ-017 outstanding_o  output  3  number of busy slots.
REQ-018 overflow_o  output  1  sticky: read dropped because all slots were busy.

Function
REQ-019 Read command detected at edge T when enable_i=1, any chip_select_i bit=0 and command_address_i[4:0]=5'b01111.
REQ-020 On detection, the lowest-index free slot captures T-relative timing and chip_select_i; the slot's window parameters shall be sampled at edge T+1 (second command cycle, after the CA manager resolves BL).
REQ-021 Burst clocks B: BL16=8, BC8=4, BL32=16; plus 1 when dram_crc_en_i=1.
REQ-022 Preamble clocks P: code 000=1, 001=2, 010=2, 011=3, 100=4, 101..111=2.
REQ-023 Postamble clocks Q: code 0=1, 1=2.
REQ-024 Per slot, the gate is high for edges T+RL-P through T+RL+B+Q-1 inclusive; the data window is high for T+RL through T+RL+B-1; the start pulse occurs at T+RL.
REQ-025 The "at edge N" outputs are registered: their values are visible in the cycle following edge N.
REQ-026 dqs_gate_o and rd_window_o = OR across all busy slots; overlapping or abutting windows shall merge with no low gap.
REQ-027 rd_burst_start_o = OR of the per-slot start events; rd_rank_o updates on each start and holds otherwise.
REQ-028 A slot frees on the edge after its gate end; it is reusable for a command detected on that same edge.
REQ-029 RL is sampled at T; later changes do not affect in-flight slots.
REQ-030 Detection with all slots busy: command is dropped and overflow_o is set until reset; the state of the busy slots is unaffected.
REQ-031 enable_i=0 blocks only new captures; in-flight slots continue.
REQ-032 outstanding_o counts busy slots after each edge; capture and free on the same edge shall net correctly.
REQ-033 A CA value matching the read pattern at edge T+1 of an accepted read is the second cycle, not a new read.

Reset
REQ-034 rst_i=0 at an edge clears all slots, outputs and overflow_o; all outputs are 0 after that edge, including mid-window.
REQ-035 The first command can be captured on the first edge with rst_i=1.

Verification
REQ-036 RL=20, BL16, pre 010, post 0, CRC off, read at T=10 -> gate 28..38, window 30..37, start pulse 30.
REQ-037 Same setup, second read at T=18 -> gate continuous from 28 to 46, two start pulses (30, 38), outstanding_o peaks at 2.
REQ-038 BC8, CRC on, pre 100, post 1, RL=12 -> B=5, gate T+8..T+18, window T+12..T+16.
REQ-039 Five reads spaced 2 clocks apart, RL=40 -> the fifth is dropped, overflow_o=1, four windows generated.
REQ-040 rst_i low during a window -> all outputs 0 after that edge; a new read afterwards times correctly.
REQ-041 enable_i=0 with a read pattern -> no capture; a pending window completes unaffected.
